// File: rtl/regfile_wb_arbiter.sv
// Merges two writeback requesters onto the single register file write port.
// Each requester has a one-entry buffer; a round-robin arbiter drains one buffer per cycle.
module regfile_wb_arbiter #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic             rs1_pending,
    output logic             rs2_pending,
    output logic             we,
    output logic [AW-1:0]    write_reg,
    output logic [WIDTH-1:0] write_data,
    output logic [1:0]       gnt,
    output logic             busy
);

    logic             full0, full1, last;
    logic [AW-1:0]    addr0, addr1;
    logic [WIDTH-1:0] data0, data1;
    logic             full0_nx, full1_nx, last_nx;
    logic             take0, take1;

    // Grant comes only from buffer state; incoming requests never bypass the buffers.
    always_comb begin
        gnt = 2'b00;
        if (full0 && full1) gnt = last ? 2'b01 : 2'b10;
        else if (full0)     gnt = 2'b01;
        else if (full1)     gnt = 2'b10;
    end

    assign req0_ready = !full0 || gnt[0];
    assign req1_ready = !full1 || gnt[1];
    assign take0      = req0_valid && req0_ready;
    assign take1      = req1_valid && req1_ready;

    always_comb begin
        full0_nx = take0 || (full0 && !gnt[0]);
        full1_nx = take1 || (full1 && !gnt[1]);
        last_nx  = last;
        if (gnt[0])      last_nx = 1'b0;
        else if (gnt[1]) last_nx = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full0 <= 1'b0;
            full1 <= 1'b0;
            last  <= 1'b1;
            addr0 <= '0;
            addr1 <= '0;
            data0 <= '0;
            data1 <= '0;
        end else begin
            full0 <= full0_nx;
            full1 <= full1_nx;
            last  <= last_nx;
            if (take0) begin
                addr0 <= req0_addr;
                data0 <= req0_data;
            end
            if (take1) begin
                addr1 <= req1_addr;
                data1 <= req1_data;
            end
        end
    end

    // x0 entries still take the grant slot but never raise we.
    always_comb begin
        write_reg  = '0;
        write_data = '0;
        if (gnt[0]) begin
            write_reg  = addr0;
            write_data = data0;
        end else if (gnt[1]) begin
            write_reg  = addr1;
            write_data = data1;
        end
        we          = (gnt != 2'b00) && (write_reg != '0);
        rs1_pending = (rs1_addr != '0) &&
                      ((full0 && addr0 == rs1_addr) || (full1 && addr1 == rs1_addr));
        rs2_pending = (rs2_addr != '0) &&
                      ((full0 && addr0 == rs2_addr) || (full1 && addr1 == rs2_addr));
        busy        = full0 || full1;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a buffer/regfile reference model.
module tb_regfile_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_addr, req1_addr, rs1_addr, rs2_addr, write_reg;
    logic [7:0] req0_data, req1_data, write_data;
    logic       rs1_pending, rs2_pending, we, busy;
    logic [1:0] gnt;

    regfile_wb_arbiter #(.WIDTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .we(we), .write_reg(write_reg), .write_data(write_data), .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // next-cycle stimulus, applied at the following negedge by step()
    logic       nv[2];
    logic [2:0] na[2];
    logic [7:0] nd[2];
    logic [2:0] nrs1, nrs2;

    // reference model: two holding slots, round-robin pointer, register file image
    logic       m_full[2];
    logic [2:0] m_addr[2];
    logic [7:0] m_data[2];
    int         m_last;
    logic [7:0] m_rf[8];
    logic [7:0] dut_rf[8];
    logic       last_ready[2];

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_last = 1;
        last_ready[0] = 1; last_ready[1] = 1;
    endtask

    task automatic step();
        int   pick;
        logic any, e_we, e_p1, e_p2;
        logic [2:0] e_reg;
        logic [7:0] e_dat;
        logic [1:0] e_gnt;
        logic e_rdy[2];
        @(negedge clk);
        req0_valid = nv[0]; req0_addr = na[0]; req0_data = nd[0];
        req1_valid = nv[1]; req1_addr = na[1]; req1_data = nd[1];
        rs1_addr = nrs1; rs2_addr = nrs2;
        #1;
        any  = m_full[0] || m_full[1];
        pick = (m_full[0] && m_full[1]) ? 1 - m_last : (m_full[0] ? 0 : 1);
        e_gnt = any ? (2'b01 << pick) : 2'b00;
        e_reg = any ? m_addr[pick] : 3'd0;
        e_dat = any ? m_data[pick] : 8'd0;
        e_we  = any && (m_addr[pick] != 0);
        for (int i = 0; i < 2; i++) e_rdy[i] = !m_full[i] || (any && pick == i);
        e_p1 = (nrs1 != 0) && ((m_full[0] && m_addr[0] == nrs1) || (m_full[1] && m_addr[1] == nrs1));
        e_p2 = (nrs2 != 0) && ((m_full[0] && m_addr[0] == nrs2) || (m_full[1] && m_addr[1] == nrs2));
        check("gnt", gnt, e_gnt);
        check("we", we, e_we);
        check("write_reg", write_reg, e_reg);
        check("write_data", write_data, e_dat);
        check("req0_ready", req0_ready, e_rdy[0]);
        check("req1_ready", req1_ready, e_rdy[1]);
        check("rs1_pending", rs1_pending, e_p1);
        check("rs2_pending", rs2_pending, e_p2);
        check("busy", busy, any);
        if (we) dut_rf[write_reg] = write_data;
        if (any) begin
            if (m_addr[pick] != 0) m_rf[m_addr[pick]] = m_data[pick];
            m_full[pick] = 0;
            m_last = pick;
        end
        for (int i = 0; i < 2; i++) begin
            last_ready[i] = e_rdy[i];
            if (nv[i] && e_rdy[i]) begin
                m_full[i] = 1; m_addr[i] = na[i]; m_data[i] = nd[i];
            end
        end
    endtask

    // a requester whose offer was refused keeps presenting the same write
    task automatic gen(input int pv);
        for (int i = 0; i < 2; i++) begin
            if (!(nv[i] && !last_ready[i])) begin
                nv[i] = ($urandom_range(99) < pv);
                na[i] = 3'($urandom_range(7));
                nd[i] = 8'($urandom_range(255));
            end
        end
        nrs1 = 3'($urandom_range(7));
        nrs2 = 3'($urandom_range(7));
    endtask

    task automatic idle();
        nv[0] = 0; nv[1] = 0; nrs1 = 0; nrs2 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        check("rst_we", we, 0);
        check("rst_gnt", gnt, 0);
        check("rst_ready", {req1_ready, req0_ready}, 2'b11);
        check("rst_busy", busy, 0);
        check("rst_wreg", write_reg, 0);
        check("rst_wdata", write_data, 0);
        model_reset();
        @(posedge clk);
        #2;
        check("rst_hold_we", we, 0);
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_rf[i] = 0; dut_rf[i] = 0; end
        for (int i = 0; i < 2; i++) begin nv[i] = 0; na[i] = 0; nd[i] = 0; end
        nrs1 = 0; nrs2 = 0;
        req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
        req0_data = 0; req1_data = 0; rs1_addr = 0; rs2_addr = 0;
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 0;

        // reset while both buffers hold writes
        idle(); nv[0] = 1; na[0] = 3'd3; nd[0] = 8'h33; nv[1] = 1; na[1] = 3'd4; nd[1] = 8'h44;
        step();
        do_reset();
        idle(); nrs1 = 3'd3; nrs2 = 3'd4;
        step();
        check("post_rst_we", we, 0);
        check("post_rst_pend", {rs2_pending, rs1_pending}, 2'b00);

        // single req0 write r3 = A5
        idle(); nv[0] = 1; na[0] = 3'd3; nd[0] = 8'hA5;
        step();
        idle(); nrs1 = 3'd3;
        step();
        check("t2_we", we, 1);
        check("t2_reg", write_reg, 3);
        check("t2_data", write_data, 8'hA5);
        check("t2_gnt", gnt, 2'b01);
        check("t2_pend", rs1_pending, 1);
        idle(); nrs1 = 3'd3;
        step();
        check("t2_pend_clr", rs1_pending, 0);

        // simultaneous r1/r2 after reset: req0 wins the tie
        do_reset();
        idle(); nv[0] = 1; na[0] = 3'd1; nd[0] = 8'h11; nv[1] = 1; na[1] = 3'd2; nd[1] = 8'h22;
        step();
        idle(); step();
        check("t3_gnt_a", gnt, 2'b01);
        check("t3_reg_a", write_reg, 1);
        step();
        check("t3_gnt_b", gnt, 2'b10);
        check("t3_reg_b", write_reg, 2);
        step();

        // continuous contention: alternating grants
        for (int k = 0; k < 10; k++) begin
            gen(100);
            step();
            if (k >= 2) check("t4_alt", gnt, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        idle(); repeat (3) step();

        // req1 write to x0 drains without writing
        idle(); nv[1] = 1; na[1] = 3'd0; nd[1] = 8'hFF;
        step();
        idle();
        step();
        check("t5_gnt", gnt, 2'b10);
        check("t5_we", we, 0);
        check("t5_pend", {rs2_pending, rs1_pending}, 2'b00);
        step();
        check("t5_drained", busy, 0);

        // back-to-back req0 writes
        for (int k = 0; k < 3; k++) begin
            idle(); nv[0] = 1; na[0] = 3'(4 + k); nd[0] = 8'(k + 1);
            step();
            check("t6_ready", req0_ready, 1);
        end
        idle();
        step(); check("t6_w6", {we, write_reg, write_data}, {1'b1, 3'd6, 8'd3});
        step();

        // random traffic with one reset in the middle
        idle();
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                do_reset();
                idle();
            end
            gen(60);
            step();
        end
        idle(); repeat (3) step();

        for (int i = 1; i < 8; i++) check($sformatf("rf_r%0d", i), dut_rf[i], m_rf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
